// File: rtl/mem_model_pkg.sv
// Shared types and helpers for the parametrised memory responder.
// Build option: MEM_MODEL_RAND_LAT_EN selects randomised response latency.
package mem_model_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } mem_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } mem_op_t;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [63:0] byte_merge(
        input logic [63:0] old_data,
        input logic [63:0] new_data,
        input logic [7:0]  mask
    );
        logic [63:0] r;
        r = old_data;
        for (int i = 0; i < 8; i++) begin
            if (mask[i]) begin
                r[8*i +: 8] = new_data[8*i +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_model_param_lfsr.sv
// 16-bit Galois LFSR used to randomise response latency.
// Only instantiated when MEM_MODEL_RAND_LAT_EN is defined.
module mem_lfsr16
    import mem_model_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] state
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= 16'h0001;
        end else if (en) begin
            state <= {1'b0, state[15:1]} ^ (state[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/mem_model_param.sv
// Parametrised single-port memory responder with configurable latency.
// Build option: MEM_MODEL_RAND_LAT_EN adds LFSR-driven random extra latency.
module mem_model_param
    import mem_model_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int DEPTH_WORDS   = 256,
    parameter int LATENCY       = 3,
    parameter int LAT_RAND_MASK = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    resp,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    err
);

    localparam int NBYTES = DATA_WIDTH / 8;
    localparam int OFFS   = $clog2(NBYTES);
    localparam int MEM_AW = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = 16;

    mem_state_t            state_q, state_d;
    mem_op_t               op_q, req_op;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [NBYTES-1:0]     wmask_q;
    logic [CNT_W-1:0]      cnt_q, cnt_d, load_val, rand_extra;
    logic                  err_seen_q, err_seen_d;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [MEM_AW-1:0]     mem_idx;
    logic                  in_range;
    logic                  mismatch;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

`ifdef MEM_MODEL_RAND_LAT_EN
    logic [15:0] lfsr;

    mem_lfsr16 u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .state (lfsr)
    );

    assign rand_extra = lfsr & 16'(LAT_RAND_MASK);
`else
    assign rand_extra = '0;
`endif

    assign load_val = CNT_W'(LATENCY - 1) + rand_extra;
    assign word_idx = addr_q >> OFFS;
    assign mem_idx  = word_idx[MEM_AW-1:0];
    assign in_range = (word_idx >> MEM_AW) == '0;
    assign req_op   = write ? OP_WRITE : OP_READ;

    // Held request must stay a single op at the same address until resp
    assign mismatch = !(read ^ write) || (req_op != op_q) ||
                      (address != addr_q);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        err_seen_d = err_seen_q;
        accept     = 1'b0;
        resp       = 1'b0;
        err        = 1'b0;
        rdata      = '0;
        unique case (state_q)
            IDLE: begin
                if (read && write) begin
                    err = 1'b1;
                end else if (read || write) begin
                    accept     = 1'b1;
                    cnt_d      = load_val;
                    err_seen_d = 1'b0;
                    state_d    = (load_val == '0) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (mismatch && !err_seen_q) begin
                    err        = 1'b1;
                    err_seen_d = 1'b1;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                resp    = 1'b1;
                err     = !in_range;
                state_d = IDLE;
                if (op_q == OP_READ && in_range) begin
                    rdata = mem[mem_idx];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            err_seen_q <= 1'b0;
            op_q       <= OP_READ;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            err_seen_q <= err_seen_d;
            if (accept) begin
                op_q    <= req_op;
                addr_q  <= address;
                wdata_q <= wdata;
                wmask_q <= wmask;
            end
        end
    end

    // Storage has no reset; an aborted write never reaches RESP
    always_ff @(posedge clk) begin
        if (state_q == RESP && op_q == OP_WRITE && in_range) begin
            mem[mem_idx] <= DATA_WIDTH'(byte_merge(64'(mem[mem_idx]),
                                                   64'(wdata_q),
                                                   8'(wmask_q)));
        end
    end

endmodule

// File: tb/tb_mem_model_param.sv
// Self-checking bench for mem_model_param against a byte-level memory model.
// Honours MEM_MODEL_RAND_LAT_EN when checking latency ranges.
module tb_mem_model_param;

    localparam int LAT   = 3;
    localparam int DEPTH = 256;
    localparam int NOPS  = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [1:0]  wmask = '0;
    logic [15:0] address = '0;
    logic [15:0] wdata = '0;
    logic        resp;
    logic [15:0] rdata;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [15:0] ref_mem [DEPTH];
    logic [1:0]  known   [DEPTH];

    bit          op_wr [NOPS];
    logic [15:0] op_a  [NOPS];
    logic [15:0] op_d  [NOPS];
    logic [1:0]  op_m  [NOPS];
    int          lat1  [NOPS];

    mem_model_param #(
        .DATA_WIDTH    (16),
        .ADDR_WIDTH    (16),
        .DEPTH_WORDS   (DEPTH),
        .LATENCY       (LAT),
        .LAT_RAND_MASK (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .read    (read),
        .write   (write),
        .wmask   (wmask),
        .address (address),
        .wdata   (wdata),
        .resp    (resp),
        .rdata   (rdata),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit lat_ok(input int l);
`ifdef MEM_MODEL_RAND_LAT_EN
        return (l >= LAT) && (l <= LAT + 3);
`else
        return l == LAT;
`endif
    endfunction

    // Called at a negedge with the responder idle; returns one idle cycle later
    task automatic xact(input bit is_wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] m,
                        output logic [15:0] rd, output int lat,
                        output bit e);
        read    = !is_wr;
        write   = is_wr;
        address = a;
        wdata   = d;
        wmask   = m;
        lat     = 0;
        e       = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (err) e = 1'b1;
        end while (!resp && lat < 24);
        rd    = rdata;
        read  = 1'b0;
        write = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_op(input string tag, input bit is_wr,
                          input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] m, output logic [15:0] rd);
        int   lat;
        bit   e;
        int   idx;
        bit   oor;
        logic [15:0] km;
        idx = int'(a) >> 1;
        oor = idx >= DEPTH;
        xact(is_wr, a, d, m, rd, lat, e);
        chk({tag, "_lat"}, 32'(lat_ok(lat)), 32'd1);
        chk({tag, "_err"}, 32'(e), 32'(oor));
        if (is_wr) begin
            if (!oor) begin
                for (int b = 0; b < 2; b++) begin
                    if (m[b]) begin
                        ref_mem[idx][8*b +: 8] = d[8*b +: 8];
                        known[idx][b] = 1'b1;
                    end
                end
            end
        end else if (oor) begin
            chk({tag, "_oor_rd"}, 32'(rd), 32'd0);
        end else begin
            km = {{8{known[idx][1]}}, {8{known[idx][0]}}};
            chk({tag, "_rd"}, 32'(rd & km), 32'(ref_mem[idx] & km));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [15:0] rd;
        int lat;
        bit e;
        int ecnt;
        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = '0;
            known[i]   = '0;
        end

        repeat (2) @(negedge clk);
        chk("rst_resp", 32'(resp), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("wr_beef", 1'b1, 16'h0010, 16'hBEEF, 2'b11, rd);
        run_op("rd_beef", 1'b0, 16'h0010, 16'h0000, 2'b00, rd);
        chk("beef_val", 32'(rd), 32'hBEEF);

        run_op("wr_1234", 1'b1, 16'h0020, 16'h1234, 2'b11, rd);
        run_op("wr_mask", 1'b1, 16'h0020, 16'hABCD, 2'b10, rd);
        run_op("rd_mask", 1'b0, 16'h0020, 16'h0000, 2'b00, rd);
        chk("mask_val", 32'(rd), 32'hAB34);

        run_op("wr_m0", 1'b1, 16'h0020, 16'h5555, 2'b00, rd);
        run_op("rd_m0", 1'b0, 16'h0020, 16'h0000, 2'b00, rd);
        chk("m0_val", 32'(rd), 32'hAB34);

        read  = 1'b1;
        write = 1'b1;
        address = 16'h0010;
        #1;
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_resp", 32'(resp), 32'd0);
        @(negedge clk);
        read  = 1'b0;
        write = 1'b0;
        #1;
        chk("ill_err_drop", 32'(err), 32'd0);
        repeat (LAT + 4) begin
            @(negedge clk);
            chk("ill_no_resp", 32'(resp), 32'd0);
        end
        run_op("ill_rd", 1'b0, 16'h0010, 16'h0000, 2'b00, rd);
        chk("ill_rd_val", 32'(rd), 32'hBEEF);

        run_op("wr_w0", 1'b1, 16'h0000, 16'h0F0F, 2'b11, rd);
        run_op("oor_rd", 1'b0, 16'h0200, 16'h0000, 2'b00, rd);
        run_op("oor_wr", 1'b1, 16'h0200, 16'hFFFF, 2'b11, rd);
        run_op("rd_w0", 1'b0, 16'h0000, 16'h0000, 2'b00, rd);
        chk("w0_val", 32'(rd), 32'h0F0F);

        run_op("wr_pre", 1'b1, 16'h0004, 16'h1111, 2'b11, rd);
        write   = 1'b1;
        address = 16'h0004;
        wdata   = 16'h5A5A;
        wmask   = 2'b11;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rstmid_resp", 32'(resp), 32'd0);
        @(negedge clk);
        chk("rstmid_resp_hold", 32'(resp), 32'd0);
        rst   = 1'b0;
        write = 1'b0;
        repeat (LAT + 4) begin
            @(negedge clk);
            chk("rstmid_after", 32'(resp), 32'd0);
        end
        run_op("rstmid_rd", 1'b0, 16'h0004, 16'h0000, 2'b00, rd);
        chk("rstmid_val", 32'(rd), 32'h1111);

        write   = 1'b1;
        address = 16'h0030;
        wdata   = 16'h7777;
        wmask   = 2'b11;
        ecnt    = 0;
        @(negedge clk);
        address = 16'h0032;
        #1;
        if (err) ecnt++;
        lat = 1;
        do begin
            @(negedge clk);
            lat++;
            if (err) ecnt++;
        end while (!resp && lat < 24);
        chk("chg_resp", 32'(resp), 32'd1);
        chk("chg_err_once", 32'(ecnt), 32'd1);
        write = 1'b0;
        @(negedge clk);
        ref_mem[24] = 16'h7777;
        known[24]   = 2'b11;
        run_op("chg_rd", 1'b0, 16'h0030, 16'h0000, 2'b00, rd);
        chk("chg_val", 32'(rd), 32'h7777);

        for (int i = 0; i < NOPS; i++) begin
            op_wr[i] = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) begin
                op_a[i] = 16'($urandom_range(16'h0200, 16'hFFFF));
            end else begin
                op_a[i] = 16'($urandom_range(0, 16'h01FF));
            end
            op_d[i] = 16'($urandom);
            op_m[i] = 2'($urandom_range(0, 3));
        end

        do_reset();
        for (int i = 0; i < NOPS; i++) begin
            run_op("rnd", op_wr[i], op_a[i], op_d[i], op_m[i], rd);
        end

        do_reset();
        for (int i = 0; i < NOPS; i++) begin
            xact(op_wr[i], op_a[i], op_d[i], op_m[i], rd, lat, e);
            lat1[i] = lat;
        end
        do_reset();
        for (int i = 0; i < NOPS; i++) begin
            xact(op_wr[i], op_a[i], op_d[i], op_m[i], rd, lat, e);
            chk("rep_lat", 32'(lat), 32'(lat1[i]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
